// File: rtl/ptcalc_sched.sv
// ptcalc_sched: round-robin scheduler sharing one HLS pT-calculation core among N_REQ requesters,
// with payload latching, result tagging and a hung-core timeout/abort.
module ptcalc_sched #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = 2
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                is_C_side,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*58-1:0] req_pl,
  input  logic [N_REQ*64-1:0] req_sf_inn,
  input  logic [N_REQ*64-1:0] req_sf_mid,
  input  logic [N_REQ*64-1:0] req_sf_out,
  output logic                core_rst,
  output logic                core_start,
  output logic                core_is_C_side,
  input  logic                core_ready,
  input  logic                core_done,
  input  logic                core_idle,
  output logic [57:0]         core_pl,
  output logic [63:0]         core_sf_inn,
  output logic [63:0]         core_sf_mid,
  output logic [63:0]         core_sf_out,
  input  logic [53:0]         core_res,
  input  logic                core_res_vld,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [53:0]         out_data,
  output logic [ID_W-1:0]     out_id,
  output logic                out_err,
  output logic [15:0]         stat_done_cnt,
  output logic [7:0]          stat_tmo_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, ABORT} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, id_q, gnt_id, rr_nxt;
  logic [ID_W:0] sum;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0] rot;
  logic [TW-1:0] tmo_q;
  logic found, busy, tmo_hit, vld_seen_q, err_q;
  logic [53:0] res_q;
  logic [57:0] pl_q, g_pl;
  logic [63:0] inn_q, mid_q, out_q, g_inn, g_mid, g_out;
  logic [15:0] done_cnt_q;
  logic [7:0] tmo_cnt_q;
  logic unused_idle;
  assign unused_idle = core_idle;
  // Rotate requests so that bit 0 is rr_ptr; the first set bit is the winner.
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    sum = '0;
    dbl = {req_valid, req_valid} >> rr_ptr_q;
    rot = dbl[N_REQ-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
        gnt_id = (sum >= N_REQ) ? ID_W'(sum - N_REQ) : ID_W'(sum);
      end
    end
    g_pl = '0;
    g_inn = '0;
    g_mid = '0;
    g_out = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt_id) begin
        g_pl = req_pl[58*i +: 58];
        g_inn = req_sf_inn[64*i +: 64];
        g_mid = req_sf_mid[64*i +: 64];
        g_out = req_sf_out[64*i +: 64];
      end
    end
  end
  always_comb begin
    busy = state_q == START || state_q == WAIT;
    tmo_hit = busy && tmo_q == TW'(TIMEOUT - 1) && !core_done;
    rr_nxt = (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = found ? START : IDLE;
      START:   state_d = tmo_hit ? ABORT : !core_ready ? START : core_done ? RESP : WAIT;
      WAIT:    state_d = tmo_hit ? ABORT : core_done ? RESP : WAIT;
      ABORT:   state_d = RESP;
      RESP:    state_d = out_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      id_q <= '0;
      tmo_q <= '0;
      vld_seen_q <= 1'b0;
      err_q <= 1'b0;
      res_q <= '0;
      pl_q <= '0;
      inn_q <= '0;
      mid_q <= '0;
      out_q <= '0;
      done_cnt_q <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        id_q <= gnt_id;
        pl_q <= g_pl;
        inn_q <= g_inn;
        mid_q <= g_mid;
        out_q <= g_out;
        tmo_q <= '0;
        vld_seen_q <= 1'b0;
        err_q <= 1'b0;
        res_q <= '0;
      end
      if (busy) tmo_q <= tmo_q + 1'b1;
      if (busy && core_res_vld) begin
        res_q <= core_res;
        vld_seen_q <= 1'b1;
      end
      if (busy && state_d == RESP) err_q <= !(vld_seen_q || core_res_vld);
      if (state_q == ABORT) begin
        res_q <= '0;
        err_q <= 1'b1;
        if (tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (state_q == RESP && out_ready) begin
        done_cnt_q <= done_cnt_q + 1'b1;
        rr_ptr_q <= rr_nxt;
      end
    end
  end
  assign req_ready = (state_q == IDLE && found && !ap_rst) ? N_REQ'(1) << gnt_id : '0;
  assign core_rst = ap_rst || state_q == ABORT;
  assign core_start = state_q == START && !ap_rst;
  assign core_is_C_side = is_C_side;
  assign core_pl = pl_q;
  assign core_sf_inn = inn_q;
  assign core_sf_mid = mid_q;
  assign core_sf_out = out_q;
  assign out_valid = state_q == RESP && !ap_rst;
  assign out_data = res_q;
  assign out_id = id_q;
  assign out_err = err_q;
  assign stat_done_cnt = done_cnt_q;
  assign stat_tmo_cnt = tmo_cnt_q;
endmodule

// File: tb/tb_ptcalc_sched.sv
// tb_ptcalc_sched: directed bench for ptcalc_sched with a hand-driven core model.
module tb_ptcalc_sched;
  logic ap_clk = 1'b0, ap_rst = 1'b1, is_C_side = 1'b1;
  logic [3:0] req_valid = '0, req_ready;
  logic [4*58-1:0] req_pl;
  logic [4*64-1:0] req_sf_inn, req_sf_mid, req_sf_out;
  logic core_rst, core_start, core_is_C_side;
  logic core_ready = 1'b0, core_done = 1'b0, core_idle = 1'b1, core_res_vld = 1'b0;
  logic [57:0] core_pl;
  logic [63:0] core_sf_inn, core_sf_mid, core_sf_out;
  logic [53:0] core_res = '0, out_data;
  logic out_valid, out_ready = 1'b0, out_err;
  logic [1:0] out_id;
  logic [15:0] stat_done_cnt;
  logic [7:0] stat_tmo_cnt;
  int cmp = 0, err = 0;

  ptcalc_sched #(.N_REQ(4), .TIMEOUT(64), .ID_W(2)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .is_C_side(is_C_side),
    .req_valid(req_valid), .req_ready(req_ready), .req_pl(req_pl),
    .req_sf_inn(req_sf_inn), .req_sf_mid(req_sf_mid), .req_sf_out(req_sf_out),
    .core_rst(core_rst), .core_start(core_start), .core_is_C_side(core_is_C_side),
    .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle),
    .core_pl(core_pl), .core_sf_inn(core_sf_inn), .core_sf_mid(core_sf_mid), .core_sf_out(core_sf_out),
    .core_res(core_res), .core_res_vld(core_res_vld),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .out_err(out_err),
    .stat_done_cnt(stat_done_cnt), .stat_tmo_cnt(stat_tmo_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [57:0] plv(int i);
    return 58'h2AB_CDEF_0123_4567 + 58'(i * 'h1111);
  endfunction

  function automatic logic [63:0] sfv(int i, int k);
    return 64'hA5A5_0000_0000_0000 ^ 64'((k << 8) | i);
  endfunction

  task automatic nc();
    @(negedge ap_clk);
    #1;
  endtask

  task automatic accept();
    req_valid = '0;
    out_ready = 1'b1;
    nc();
    out_ready = 1'b0;
  endtask

  // Grants a job and runs the core handshake; returns in RESP.
  task automatic job_run(input logic [3:0] v, input int lat, input logic gv, input logic [53:0] r,
                         output logic [3:0] rdy, output logic [57:0] pl, output logic [63:0] mid);
    int n = 0;
    req_valid = v;
    #1;
    while (req_ready == 0 && n < 20) begin nc(); n++; end
    cmp++; if (n >= 20) begin err++; $display("FAIL grant_wait: req_ready=%b required nonzero", req_ready); end
    rdy = req_ready;
    nc();
    pl = core_pl;
    mid = core_sf_mid;
    core_ready = 1'b1;
    if (lat == 0) begin core_done = 1'b1; core_res_vld = gv; core_res = r; end
    nc();
    {core_ready, core_done, core_res_vld} = '0;
    if (lat > 0) begin
      repeat (lat - 1) nc();
      core_done = 1'b1;
      core_res_vld = gv;
      core_res = r;
      nc();
      {core_done, core_res_vld} = '0;
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    nc();
    nc();
    cmp++; if (core_rst !== 1'b1) begin err++; $display("FAIL rst_core_rst: got %b exp 1", core_rst); end
    cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    cmp++; if (core_start !== 1'b0) begin err++; $display("FAIL rst_core_start: got %b exp 0", core_start); end
    cmp++; if (core_pl !== 58'h0) begin err++; $display("FAIL rst_core_pl: got %h exp 0", core_pl); end
    cmp++; if (stat_done_cnt !== 16'h0 || stat_tmo_cnt !== 8'h0) begin err++; $display("FAIL rst_stats: got %h/%h exp 0/0", stat_done_cnt, stat_tmo_cnt); end
    ap_rst = 1'b0;
    #1;
    cmp++; if (core_rst !== 1'b0) begin err++; $display("FAIL rst_release: core_rst got %b exp 0", core_rst); end
    cmp++; if (core_is_C_side !== 1'b1) begin err++; $display("FAIL c_side: got %b exp 1", core_is_C_side); end
  endtask

  task automatic test_fairness();
    logic [3:0] rdy;
    logic [57:0] pl;
    logic [63:0] mid;
    for (int k = 0; k < 8; k++) begin
      job_run(4'hF, 1, 1'b1, 54'(k + 7), rdy, pl, mid);
      cmp++; if (rdy !== 4'(1 << (k % 4))) begin err++; $display("FAIL fair_grant%0d: got %b exp %b", k, rdy, 4'(1 << (k % 4))); end
      cmp++; if (pl !== plv(k % 4) || mid !== sfv(k % 4, 1)) begin err++; $display("FAIL fair_payload%0d: got %h/%h exp %h/%h", k, pl, mid, plv(k % 4), sfv(k % 4, 1)); end
      cmp++; if (out_valid !== 1'b1 || out_id !== 2'(k % 4) || out_data !== 54'(k + 7)) begin err++; $display("FAIL fair_result%0d: got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", k, out_valid, out_id, out_data, k % 4, k + 7); end
      accept();
    end
    cmp++; if (stat_done_cnt !== 16'd8) begin err++; $display("FAIL fair_done_cnt: got %0d exp 8", stat_done_cnt); end
  endtask

  task automatic test_single();
    logic [3:0] rdy;
    logic [57:0] pl;
    logic [63:0] mid;
    job_run(4'b0010, 5, 1'b1, 54'h2A5, rdy, pl, mid);
    cmp++; if (rdy !== 4'b0010) begin err++; $display("FAIL single_grant: got %b exp 0010", rdy); end
    cmp++; if (pl !== plv(1)) begin err++; $display("FAIL single_pl: got %h exp %h", pl, plv(1)); end
    cmp++; if (out_valid !== 1'b1 || out_data !== 54'h2A5 || out_id !== 2'd1 || out_err !== 1'b0) begin err++; $display("FAIL single_result: got v=%b d=%h id=%0d e=%b exp 1/2a5/1/0", out_valid, out_data, out_id, out_err); end
    accept();
    cmp++; if (stat_done_cnt !== 16'd9 || out_valid !== 1'b0) begin err++; $display("FAIL single_done: got cnt=%0d v=%b exp 9/0", stat_done_cnt, out_valid); end
  endtask

  task automatic test_backpressure();
    logic [3:0] rdy;
    logic [57:0] pl;
    logic [63:0] mid;
    job_run(4'hF, 2, 1'b1, 54'h1F_0000_ABCD, rdy, pl, mid);
    cmp++; if (rdy !== 4'b0100) begin err++; $display("FAIL bp_grant: got %b exp 0100", rdy); end
    for (int k = 0; k < 10; k++) begin
      cmp++;
      if (out_valid !== 1'b1 || out_data !== 54'h1F_0000_ABCD || out_id !== 2'd2 || req_ready !== 4'b0 || core_start !== 1'b0) begin
        err++;
        $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d rdy=%b st=%b exp 1/1f0000abcd/2/0000/0", k, out_valid, out_data, out_id, req_ready, core_start);
      end
      nc();
    end
    accept();
    cmp++; if (stat_done_cnt !== 16'd10) begin err++; $display("FAIL bp_done_cnt: got %0d exp 10", stat_done_cnt); end
  endtask

  task automatic test_timeout();
    logic [3:0] rdy;
    logic [57:0] pl;
    logic [63:0] mid;
    int n = 0;
    req_valid = 4'b0001;
    #1;
    cmp++; if (req_ready !== 4'b0001) begin err++; $display("FAIL tmo_grant: got %b exp 0001", req_ready); end
    nc();
    req_valid = '0;
    core_ready = 1'b1;
    while (!core_rst && n < 100) begin nc(); core_ready = 1'b0; n++; end
    cmp++; if (n !== 64) begin err++; $display("FAIL tmo_abort_cycle: got %0d exp 64", n); end
    nc();
    cmp++; if (core_rst !== 1'b0) begin err++; $display("FAIL tmo_rst_pulse: got %b exp 0", core_rst); end
    cmp++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 54'h0 || out_id !== 2'd0) begin err++; $display("FAIL tmo_result: got v=%b e=%b d=%h id=%0d exp 1/1/0/0", out_valid, out_err, out_data, out_id); end
    cmp++; if (stat_tmo_cnt !== 8'd1) begin err++; $display("FAIL tmo_cnt: got %0d exp 1", stat_tmo_cnt); end
    accept();
    job_run(4'b0001, 3, 1'b1, 54'h155, rdy, pl, mid);
    cmp++; if (out_err !== 1'b0 || out_data !== 54'h155 || rdy !== 4'b0001) begin err++; $display("FAIL tmo_next_job: got e=%b d=%h rdy=%b exp 0/155/0001", out_err, out_data, rdy); end
    accept();
    cmp++; if (stat_done_cnt !== 16'd12) begin err++; $display("FAIL tmo_done_cnt: got %0d exp 12", stat_done_cnt); end
  endtask

  task automatic test_err_cases();
    logic [3:0] rdy;
    logic [57:0] pl;
    logic [63:0] mid;
    job_run(4'b0100, 4, 1'b0, 54'h3FF, rdy, pl, mid);
    cmp++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 54'h0 || out_id !== 2'd2) begin err++; $display("FAIL novld_result: got v=%b e=%b d=%h id=%0d exp 1/1/0/2", out_valid, out_err, out_data, out_id); end
    accept();
    job_run(4'b1000, 63, 1'b1, 54'h0BEEF, rdy, pl, mid);
    cmp++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== 54'h0BEEF || out_id !== 2'd3) begin err++; $display("FAIL coinc_result: got v=%b e=%b d=%h id=%0d exp 1/0/beef/3", out_valid, out_err, out_data, out_id); end
    cmp++; if (stat_tmo_cnt !== 8'd1) begin err++; $display("FAIL coinc_tmo_cnt: got %0d exp 1", stat_tmo_cnt); end
    accept();
    cmp++; if (stat_done_cnt !== 16'd14) begin err++; $display("FAIL err_done_cnt: got %0d exp 14", stat_done_cnt); end
  endtask

  task automatic test_reset_in_wait();
    logic [3:0] rdy;
    logic [57:0] pl;
    logic [63:0] mid;
    job_run(4'b0001, 1, 1'b1, 54'h11, rdy, pl, mid);
    accept();
    cmp++; if (stat_done_cnt !== 16'd15) begin err++; $display("FAIL rw_pre_cnt: got %0d exp 15", stat_done_cnt); end
    req_valid = 4'hF;
    #1;
    cmp++; if (req_ready !== 4'b0010) begin err++; $display("FAIL rw_grant: got %b exp 0010", req_ready); end
    nc();
    core_ready = 1'b1;
    nc();
    core_ready = 1'b0;
    nc();
    ap_rst = 1'b1;
    nc();
    cmp++; if (out_valid !== 1'b0 || core_start !== 1'b0 || req_ready !== 4'b0 || core_rst !== 1'b1) begin err++; $display("FAIL rw_outputs: got v=%b st=%b rdy=%b crst=%b exp 0/0/0000/1", out_valid, core_start, req_ready, core_rst); end
    cmp++; if (core_pl !== 58'h0 || stat_done_cnt !== 16'h0 || stat_tmo_cnt !== 8'h0) begin err++; $display("FAIL rw_regs: got pl=%h cnt=%0d tmo=%0d exp 0/0/0", core_pl, stat_done_cnt, stat_tmo_cnt); end
    ap_rst = 1'b0;
    req_valid = 4'b1001;
    #1;
    cmp++; if (req_ready !== 4'b0001) begin err++; $display("FAIL rw_first_grant: got %b exp 0001", req_ready); end
    nc();
    {core_ready, core_done, core_res_vld} = 3'b111;
    core_res = 54'h77;
    nc();
    {core_ready, core_done, core_res_vld} = '0;
    cmp++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 54'h77) begin err++; $display("FAIL rw_job: got v=%b id=%0d d=%h exp 1/0/77", out_valid, out_id, out_data); end
    accept();
    cmp++; if (stat_done_cnt !== 16'd1) begin err++; $display("FAIL rw_done_cnt: got %0d exp 1", stat_done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_pl[58*i +: 58] = plv(i);
      req_sf_inn[64*i +: 64] = sfv(i, 0);
      req_sf_mid[64*i +: 64] = sfv(i, 1);
      req_sf_out[64*i +: 64] = sfv(i, 2);
    end
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_timeout();
    test_err_cases();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", cmp);
    $fatal(1);
  end
endmodule

// File: doc/ptcalc_sched.md
Name: ptcalc_sched

Overview:
- Shares one HLS pT-calculation core among N_REQ candidate requesters, e.g. per-thread segment finders feeding one pT engine.
- Round-robin arbitrates requests, latches the winner's pl/segment payload and holds it stable on the core inputs.
- Runs the core's ap_start/ap_ready/ap_done handshake, captures the ptcalc2mtc result and returns it tagged with requester index.
- Guards against a hung core with a timeout and core abort.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, max cycles from core_start to core_done before abort (>=2).
- ID_W, 2, requester index width; must equal clog2(N_REQ).

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  synchronous active-high reset.
- is_C_side  in  1  static side config; passed straight to core.
- req_valid  in  N_REQ  per-requester request.
- req_ready  out  N_REQ  one-hot accept pulse.
- req_pl  in  N_REQ*58  pl2ptcalc payloads; requester i at bits [58i+57:58i].
- req_sf_inn/req_sf_mid/req_sf_out  in  N_REQ*64 each  segment payloads, same packing.
- core_rst  out  1  core reset = ap_rst OR abort pulse.
- core_start  out  1  core ap_start.
- core_ready/core_done/core_idle  in  1  core ap_ready/ap_done/ap_idle.
- core_pl  out  58  latched pl payload.
- core_sf_inn/core_sf_mid/core_sf_out  out  64 each  latched segment payloads.
- core_res  in  54  core ptcalc2mtc_V.
- core_res_vld  in  1  core ptcalc2mtc_V_ap_vld.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accept.
- out_data  out  54  result (zero on timeout or no vld).
- out_id  out  ID_W  requester index.
- out_err  out  1  1 = timeout or done without vld.
- stat_done_cnt  out  16  completed jobs, wraps.
- stat_tmo_cnt  out  8  timeouts, saturates at 255.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, every output 0 except core_rst=1 while ap_rst. core_* payload regs 0. Reset mid-job discards the job; no out_valid follows.
- States: IDLE, START, WAIT, RESP, ABORT.
- IDLE:
  - If any req_valid, pick the first set bit scanning from rr_ptr upward (mod N_REQ).
  - Pulse req_ready[w] this cycle; latch payload w and id=w; go to START.
  - No request: stay; core_start=0.
- START:
  - core_start=1, held until cycle where core_ready=1.
  - Timeout counter starts at 0 on START entry, increments every cycle in START/WAIT.
  - core_ready=1: drop core_start next cycle. If core_done also 1 that cycle, handle as WAIT completion directly; else go to WAIT.
- WAIT:
  - core_res_vld=1: capture core_res, set vld_seen.
  - core_done=1: go to RESP. Vld in same cycle as done is captured.
  - out_err = NOT vld_seen (and not vld that cycle).
- Timeout: counter reaching TIMEOUT in START/WAIT forces ABORT; ignored if core_done arrives that same cycle (done wins).
- ABORT:
  - One cycle; core_rst=1, core_start=0, out_data=0, out_err=1, stat_tmo_cnt++ (saturating).
  - Then RESP.
- RESP:
  - out_valid=1, out_data/out_id/out_err stable until out_ready=1.
  - On accept: stat_done_cnt++ (also for error results), rr_ptr = id+1 mod N_REQ, go to IDLE.
  - Accept occurs the same cycle out_ready is seen; next grant is earliest one cycle later (IDLE).
- Payload regs constant from START entry to next grant.
- req_valid deasserted without grant: no effect.
- Min throughput: one job per 4 + core-latency cycles.

Test Plan:
- Single request: req_valid=0b0010, core ready same cycle as start, done+vld 5 cycles later with res=0x2A5 -> req_ready=0b0010 pulse, out_valid with data 0x2A5, id=1, err=0, stat_done_cnt=1.
- Fairness: all 4 valid continuously, 8 jobs -> grant order 0,1,2,3,0,1,2,3; payload on core matches granted index each job.
- Backpressure: out_ready=0 for 10 cycles -> out_valid/data held stable, no new req_ready, core_start stays 0.
- Timeout: core never asserts done, TIMEOUT=64 -> ABORT 64 cycles after START entry, core_rst 1-cycle pulse, out_err=1, data=0, stat_tmo_cnt=1; next job proceeds normally.
- Done without vld and done coincident with timeout -> err=1 data=0 in first case; second case takes normal RESP, stat_tmo_cnt unchanged.
- ap_rst asserted in WAIT -> all outputs 0 next cycle, no out_valid, rr_ptr=0, first grant after reset to lowest valid index.
